uart_io_arbiter: RTL

//  Memory-mapped I/O controller between the CPU memory stage and the UART. Decodes REUART/WEUART

---
 rtl/uart_io_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/uart_io_arbiter.sv
// Memory-mapped UART I/O controller: TX/RX byte FIFOs, sticky overflow
// flags, free-running cycle counter. Ports: Clock, Reset_n, Io* bus, Ua* UART.
module uart_io_arbiter #(
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8,
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [31:0] IoAddr,
  input  logic [31:0] IoWData,
  input  logic        IoRE,
  input  logic        IoWE,
  output logic [31:0] IoRData,
  output logic [7:0]  UaTxData,
  output logic        UaTxValid,
  input  logic        UaTxReady,
  input  logic [7:0]  UaRxData,
  input  logic        UaRxValid,
  output logic        UaRxReady
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0] TX_FULL = TX_DEPTH[TAW:0];
  localparam logic [RAW:0] RX_FULL = RX_DEPTH[RAW:0];

  logic [7:0]   r_tx_mem [TX_DEPTH];
  logic [7:0]   r_rx_mem [RX_DEPTH];
  logic [TAW-1:0] r_tx_wp, r_tx_rp;
  logic [RAW-1:0] r_rx_wp, r_rx_rp;
  logic [TAW:0] r_tx_cnt;
  logic [RAW:0] r_rx_cnt;
  logic         r_tx_ovf, r_rx_ovf;
  logic [31:0]  r_cyc;
  logic [31:0]  r_rdata;

  logic        w_hit;
  logic [4:0]  w_off;
  logic        w_rd_txs, w_rd_rxs, w_rd_pop, w_rd_cyc;
  logic        w_wr_tx, w_wr_clr;
  logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic        w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic        w_tx_ovf_set, w_rx_ovf_set;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_unused = ^IoWData[31:8];

  assign w_hit    = IoAddr[31:5] == ADDR_BASE[31:5];
  assign w_off    = IoAddr[4:0];
  assign w_rd_txs = IoRE & w_hit & (w_off == 5'h00);
  assign w_rd_rxs = IoRE & w_hit & (w_off == 5'h04);
  assign w_rd_pop = IoRE & w_hit & (w_off == 5'h0C);
  assign w_rd_cyc = IoRE & w_hit & (w_off == 5'h10);
  assign w_wr_tx  = IoWE & w_hit & (w_off == 5'h08);
  assign w_wr_clr = IoWE & w_hit & (w_off == 5'h18);

  assign w_tx_full  = r_tx_cnt == TX_FULL;
  assign w_tx_empty = r_tx_cnt == '0;
  assign w_rx_full  = r_rx_cnt == RX_FULL;
  assign w_rx_empty = r_rx_cnt == '0;

  // Full-check uses start-of-cycle count: a same-cycle pop does not
  // make room for a write that arrived while full.
  assign w_tx_push    = w_wr_tx & ~w_tx_full;
  assign w_tx_ovf_set = w_wr_tx & w_tx_full;
  assign w_tx_pop     = ~w_tx_empty & UaTxReady;
  assign w_rx_push    = UaRxValid & ~w_rx_full;
  assign w_rx_ovf_set = UaRxValid & w_rx_full;
  assign w_rx_pop     = w_rd_pop & ~w_rx_empty;

  assign UaTxValid = ~w_tx_empty;
  assign UaTxData  = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rp];
  assign UaRxReady = ~w_rx_full;
  assign IoRData   = r_rdata;

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_rd_txs: w_rdata = {30'b0, r_tx_ovf, ~w_tx_full};
      w_rd_rxs: w_rdata = {30'b0, r_rx_ovf, ~w_rx_empty};
      w_rd_pop: w_rdata = w_rx_empty ? 32'h0
                        : {24'b0, r_rx_mem[r_rx_rp]};
      w_rd_cyc: w_rdata = r_cyc;
      default:  w_rdata = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= IoWData[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wp] <= UaRxData;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
      r_tx_ovf <= 1'b0;
      r_rx_ovf <= 1'b0;
      r_cyc    <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      r_tx_cnt <= r_tx_cnt + (TAW+1)'(w_tx_push)
                           - (TAW+1)'(w_tx_pop);
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      r_rx_cnt <= r_rx_cnt + (RAW+1)'(w_rx_push)
                           - (RAW+1)'(w_rx_pop);
      // A new overflow wins over a same-cycle clearing read.
      if (w_tx_ovf_set)  r_tx_ovf <= 1'b1;
      else if (w_rd_txs) r_tx_ovf <= 1'b0;
      if (w_rx_ovf_set)  r_rx_ovf <= 1'b1;
      else if (w_rd_rxs) r_rx_ovf <= 1'b0;
      r_cyc <= w_wr_clr ? 32'h0 : r_cyc + 32'h1;
      if (IoRE) r_rdata <= w_rdata;
    end
  end
endmodule
